// File: rtl/mod_sched_50.sv
`default_nettype none
// ============================================================================
// Module      : mod_sched_50
// Description : Walks a contiguous range of modulus-table ids and streams
//               each validated modulus / n0' pair over a ready/valid port.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_sched_50 #(
    parameter int ID_W   = 6,
    parameter int MAX_ID = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ID_W-1:0] base_id,
    input  logic [ID_W-1:0] num_limbs,
    input  logic            descending,
    input  logic            abort,
    output logic [ID_W-1:0] tbl_id,
    input  logic [63:0]     tbl_modulus,
    input  logic [63:0]     tbl_modulus_inv,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_limb,
    output logic [49:0]     out_modulus,
    output logic [63:0]     out_n0inv,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        EMIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [ID_W:0]   c_max_id = MAX_ID[ID_W:0];
    localparam logic [ID_W:0]   c_one_w  = {{ID_W{1'b0}}, 1'b1};
    localparam logic [ID_W-1:0] c_one    = {{(ID_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_next;
    logic [ID_W-1:0] r_id;
    logic [ID_W-1:0] r_limb;
    logic [ID_W-1:0] r_last_limb;
    logic            r_desc;
    logic [63:0]     r_mod;
    logic [63:0]     r_n0inv;
    logic            r_err;
    logic [ID_W:0]   w_end;
    logic            w_legal;
    logic            w_bad;
    logic            w_emit_ok;
    logic            w_final;
    logic            w_hs;

    // Last id of the sweep, one bit wider so an out-of-range request cannot wrap.
    assign w_end   = {1'b0, base_id} + {1'b0, num_limbs} - c_one_w;
    assign w_legal = (num_limbs != '0) && (w_end <= c_max_id);

    // An even value (which includes zero) or anything above 50 bits is unusable.
    assign w_bad     = (r_mod[63:50] != '0) || !r_mod[0];
    assign w_emit_ok = (r_state == EMIT) && !w_bad;
    assign w_final   = (r_limb == r_last_limb);
    assign w_hs      = w_emit_ok && out_ready && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start && w_legal) w_next = LOOKUP;
            LOOKUP:  w_next = abort ? IDLE : EMIT;
            EMIT: begin
                if (abort || w_bad) begin
                    w_next = IDLE;
                end else if (w_hs) begin
                    w_next = w_final ? FINISH : LOOKUP;
                end
            end
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id        <= '0;
            r_limb      <= '0;
            r_last_limb <= '0;
            r_desc      <= 1'b0;
            r_mod       <= '0;
            r_n0inv     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= (r_state == IDLE) && start && !w_legal;
            case (r_state)
                IDLE: begin
                    if (start && w_legal) begin
                        r_id        <= descending ? w_end[ID_W-1:0] : base_id;
                        r_limb      <= '0;
                        r_last_limb <= num_limbs - c_one;
                        r_desc      <= descending;
                    end
                end
                LOOKUP: begin
                    r_mod   <= tbl_modulus;
                    r_n0inv <= tbl_modulus_inv;
                end
                EMIT: begin
                    if (w_hs && !w_final) begin
                        r_id   <= r_desc ? (r_id - c_one) : (r_id + c_one);
                        r_limb <= r_limb + c_one;
                    end
                end
                default: ;
            endcase
        end
    end

    // The table sees the requested base while idle, but must read 0 under reset.
    assign tbl_id      = rst ? '0 : ((r_state == IDLE) ? base_id : r_id);
    assign out_valid   = w_emit_ok;
    assign out_last    = w_emit_ok && w_final;
    assign out_limb    = r_limb;
    assign out_modulus = r_mod[49:0];
    assign out_n0inv   = r_n0inv;
    assign busy        = (r_state == LOOKUP) || w_emit_ok;
    assign done        = (r_state == FINISH) && !abort;
    assign err         = r_err || ((r_state == EMIT) && w_bad && !abort);

endmodule
`default_nettype wire

// File: tb/tb_mod_sched_50.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_sched_50
// Description : Randomized and directed bench for mod_sched_50 with a stub
//               modulus table and a limb-sequence reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mod_sched_50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        descending = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic [5:0]  base_id = '0;
    logic [5:0]  num_limbs = '0;
    logic [5:0]  tbl_id;
    logic [63:0] tbl_modulus;
    logic [63:0] tbl_modulus_inv;
    logic        out_valid;
    logic [5:0]  out_limb;
    logic [49:0] out_modulus;
    logic [63:0] out_n0inv;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    logic [63:0] tab_mod [64];
    logic [63:0] tab_inv [64];

    int n_checks = 0;
    int n_fail   = 0;

    assign tbl_modulus     = tab_mod[tbl_id];
    assign tbl_modulus_inv = tab_inv[tbl_id];

    always #5 clk = ~clk;

    mod_sched_50 #(.ID_W(6), .MAX_ID(32)) dut (
        .clk(clk), .rst(rst), .start(start), .base_id(base_id),
        .num_limbs(num_limbs), .descending(descending), .abort(abort),
        .tbl_id(tbl_id), .tbl_modulus(tbl_modulus),
        .tbl_modulus_inv(tbl_modulus_inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_limb(out_limb), .out_modulus(out_modulus),
        .out_n0inv(out_n0inv), .out_last(out_last), .busy(busy), .done(done),
        .err(err)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"},   64'(out_valid),   64'd0);
        check_eq({tag, "_busy"},    64'(busy),        64'd0);
        check_eq({tag, "_done"},    64'(done),        64'd0);
        check_eq({tag, "_err"},     64'(err),         64'd0);
        check_eq({tag, "_last"},    64'(out_last),    64'd0);
        check_eq({tag, "_tbl_id"},  64'(tbl_id),      64'd0);
        check_eq({tag, "_limb"},    64'(out_limb),    64'd0);
        check_eq({tag, "_modulus"}, 64'(out_modulus), 64'd0);
        check_eq({tag, "_n0inv"},   out_n0inv,        64'd0);
    endtask

    // Model: each limb costs one lookup cycle, then is presented until accepted.
    // mode 0: always ready, 1: stall limb 1 for 5 cycles, 2: random ready.
    task automatic run_sweep(input int b, input int n, input bit d, input int mode, input int abort_limb);
        int ids[$];
        int k = 0, lk = 1, stall = 0, budget;
        bit exp_v, rdy, ab, hs, fin = 0, aborted = 0;
        for (int i = 0; i < n; i++) ids.push_back(d ? (b + n - 1 - i) : (b + i));
        base_id = b[5:0]; num_limbs = n[5:0]; descending = d;
        start = 1'b1; out_ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        check_eq("idle_tbl_id", 64'(tbl_id), 64'(b));
        check_eq("idle_busy", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        budget = 20 * n + 40;
        while (!fin && !aborted && budget > 0) begin
            budget--;
            exp_v = (lk == 0);
            case (mode)
                0: rdy = 1'b1;
                1: begin
                    rdy = !(exp_v && k == 1 && stall < 5);
                    if (!rdy) stall++;
                end
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            ab = exp_v && (k == abort_limb);
            out_ready = rdy;
            abort = ab;
            // A start while busy must have no effect.
            start = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
            @(negedge clk);
            check_eq("out_valid", 64'(out_valid), 64'(exp_v));
            check_eq("busy", 64'(busy), 64'd1);
            check_eq("done_early", 64'(done), 64'd0);
            check_eq("err_in_sweep", 64'(err), 64'd0);
            if (exp_v) begin
                check_eq("out_limb", 64'(out_limb), 64'(k));
                check_eq("out_modulus", 64'(out_modulus), 64'(tab_mod[ids[k]][49:0]));
                check_eq("out_n0inv", out_n0inv, tab_inv[ids[k]]);
                check_eq("out_last", 64'(out_last), 64'(k == n - 1));
            end else begin
                check_eq("lookup_tbl_id", 64'(tbl_id), 64'(ids[k]));
            end
            hs = exp_v && rdy && !ab;
            tick();
            abort = 1'b0;
            start = 1'b0;
            if (ab) aborted = 1;
            else if (lk > 0) lk--;
            else if (hs) begin
                k++;
                if (k == n) fin = 1;
                else lk = 1;
            end
        end
        out_ready = 1'b0;
        if (fin) begin
            @(negedge clk);
            check_eq("done_pulse", 64'(done), 64'd1);
            check_eq("finish_valid", 64'(out_valid), 64'd0);
            check_eq("finish_busy", 64'(busy), 64'd0);
            tick();
            @(negedge clk);
            check_eq("done_width", 64'(done), 64'd0);
            check_eq("post_busy", 64'(busy), 64'd0);
            tick();
        end else if (aborted) begin
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                check_eq("abort_busy", 64'(busy), 64'd0);
                check_eq("abort_valid", 64'(out_valid), 64'd0);
                check_eq("abort_done", 64'(done), 64'd0);
                check_eq("abort_err", 64'(err), 64'd0);
                tick();
            end
        end else begin
            check_eq("sweep_timeout", 64'd0, 64'd1);
        end
        check_eq("limbs_accepted", 64'(k), aborted ? 64'(abort_limb) : 64'(n));
    endtask

    task automatic run_illegal(input int b, input int n);
        int errs = 0, vals = 0, bsy = 0;
        base_id = b[5:0]; num_limbs = n[5:0]; descending = 1'b0;
        out_ready = 1'b1; start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (err) errs++;
            if (out_valid) vals++;
            if (busy) bsy++;
            tick();
            start = 1'b0;
        end
        check_eq("illegal_err_pulses", 64'(errs), 64'd1);
        check_eq("illegal_valid", 64'(vals), 64'd0);
        check_eq("illegal_busy", 64'(bsy), 64'd0);
        out_ready = 1'b0;
    endtask

    task automatic run_bad(input int id, input logic [63:0] bad_val);
        logic [63:0] saved;
        int errs = 0, vals = 0, dones = 0;
        saved = tab_mod[id];
        tab_mod[id] = bad_val;
        base_id = id[5:0]; num_limbs = 6'd2; descending = 1'b0;
        out_ready = 1'b1; start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (err) errs++;
            if (out_valid) vals++;
            if (done) dones++;
            tick();
            start = 1'b0;
        end
        check_eq("bad_err_pulses", 64'(errs), 64'd1);
        check_eq("bad_valid", 64'(vals), 64'd0);
        check_eq("bad_done", 64'(dones), 64'd0);
        check_eq("bad_busy_after", 64'(busy), 64'd0);
        tab_mod[id] = saved;
        out_ready = 1'b0;
    endtask

    task automatic run_reset_mid_emit();
        base_id = 6'd0; num_limbs = 6'd3; descending = 1'b0;
        out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
        #1 rst = 1'b1;
        #1 check_all_zero("mid_rst");
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("post_rst_done", 64'(done), 64'd0);
            check_eq("post_rst_err", 64'(err), 64'd0);
            check_eq("post_rst_busy", 64'(busy), 64'd0);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b, n;
        for (int i = 0; i < 64; i++) begin
            tab_mod[i] = ({$urandom, $urandom} & 64'h0003_FFFF_FFFF_FFFF) | 64'd1;
            tab_inv[i] = {$urandom, $urandom};
        end
        tab_mod[0]  = 64'h221B97B9E1E53;
        tab_mod[1]  = 64'h24702F355DA01;
        tab_mod[2]  = 64'h2485C2DD60489;
        tab_mod[30] = 64'h3D2A3F1E5D54D;
        tab_mod[31] = 64'h3E18B4D3D3753;
        tab_mod[32] = 64'h3E61FB278B617;
        tab_inv[0]  = 64'h48C8F70AACA42A25;

        rst = 1'b1;
        base_id = 6'h2A;
        tick();
        tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;

        run_sweep(0, 3, 1'b0, 0, -1);
        run_sweep(30, 3, 1'b1, 0, -1);
        run_illegal(31, 3);
        run_illegal(5, 0);
        run_sweep(0, 3, 1'b0, 1, -1);
        run_sweep(0, 3, 1'b0, 0, 1);
        run_bad(7, 64'h4);
        run_bad(9, 64'h0004_0000_0000_0001);
        run_reset_mid_emit();
        run_sweep(0, 3, 1'b0, 0, -1);
        run_sweep(0, 33, 1'b1, 0, -1);

        for (int t = 0; t < 20; t++) begin
            b = $urandom_range(0, 32);
            n = $urandom_range(1, 33 - b);
            run_sweep(b, n, ($urandom_range(0, 1) == 1), 2, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
